// File: rtl/mlp_seq_pkg.sv
// Shared types and helpers for the MLP sample sequencer.
package mlp_seq_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_EMIT   = 2'd2
  } seq_state_t;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Saturating increment; the limit is 2^w-1, so counters stick at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] lim;
    lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= lim) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mlp_seq_stats.sv
// Result statistics: saturating handshake/match counters; clear has priority over counting.
// With MLP_SEQ_TIMEOUT_EN also counts watchdog-dropped results.
module mlp_seq_stats
  import mlp_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_res_hs,
  input  logic             i_res_match,
  input  logic             i_stat_clr,
`ifdef MLP_SEQ_TIMEOUT_EN
  input  logic             i_drop,
  output logic [CNT_W-1:0] o_drop_cnt,
`endif
  output logic [CNT_W-1:0] o_total_cnt,
  output logic [CNT_W-1:0] o_correct_cnt
);

  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_correct;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total   <= '0;
      r_correct <= '0;
    end else if (i_stat_clr) begin
      r_total   <= '0;
      r_correct <= '0;
    end else if (i_res_hs) begin
      r_total <= CNT_W'(sat_inc(32'(r_total), CNT_W));
      if (i_res_match) r_correct <= CNT_W'(sat_inc(32'(r_correct), CNT_W));
    end
  end

`ifdef MLP_SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] r_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_drop <= '0;
    else if (i_stat_clr) r_drop <= '0;
    else if (i_drop)     r_drop <= CNT_W'(sat_inc(32'(r_drop), CNT_W));
  end

  assign o_drop_cnt = r_drop;
`endif

  assign o_total_cnt   = r_total;
  assign o_correct_cnt = r_correct;

endmodule

// File: rtl/mlp_sample_sequencer.sv
// Streams NUM_A features into the classifier input, waits SETTLE_CYCLES, captures and emits the class.
// Define MLP_SEQ_TIMEOUT_EN to add a result watchdog and the drop_cnt port.
module mlp_sample_sequencer
  import mlp_seq_pkg::*;
#(
  parameter int NUM_A         = 11,
  parameter int WIDTH_A       = 4,
  parameter int OUTWIDTH      = 3,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     feat_valid,
  output logic                     feat_ready,
  input  logic [WIDTH_A-1:0]       feat_data,
  input  logic [OUTWIDTH-1:0]      feat_label,
  output logic [NUM_A*WIDTH_A-1:0] clf_inp,
  input  logic [OUTWIDTH-1:0]      clf_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [OUTWIDTH-1:0]      res_class,
  output logic                     res_match,
  output logic                     busy,
  input  logic                     stat_clr,
  output logic [CNT_W-1:0]         total_cnt,
`ifdef MLP_SEQ_TIMEOUT_EN
  output logic [CNT_W-1:0]         drop_cnt,
`endif
  output logic [CNT_W-1:0]         correct_cnt
);

  localparam int IDX_W = clog2_min1(NUM_A);
  localparam int SET_W = clog2_min1(SETTLE_CYCLES + 1);

  seq_state_t               r_state;
  seq_state_t               w_state_nxt;
  logic [IDX_W-1:0]         r_idx;
  logic [SET_W-1:0]         r_set_cnt;
  logic [OUTWIDTH-1:0]      r_label;
  logic [OUTWIDTH-1:0]      r_class;
  logic                     r_match;
  logic [NUM_A*WIDTH_A-1:0] r_vec;
  logic                     w_last;
  logic                     w_feat_hs;
  logic                     w_res_hs;
  logic                     w_drop;

  assign w_last    = (r_idx == IDX_W'(NUM_A - 1));
  assign w_feat_hs = feat_valid && (r_state == ST_LOAD);
  assign w_res_hs  = res_ready && (r_state == ST_EMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    feat_ready  = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_LOAD: begin
        feat_ready = 1'b1;
        if (feat_valid && w_last) w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (r_set_cnt == '0) w_state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready || w_drop) w_state_nxt = ST_LOAD;
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  // Slots are only overwritten, never cleared, so clf_inp stays stable through SETTLE/EMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_set_cnt <= '0;
      r_label   <= '0;
      r_class   <= '0;
      r_match   <= 1'b0;
      r_vec     <= '0;
    end else begin
      if (w_feat_hs) begin
        for (int i = 0; i < NUM_A; i++) begin
          if (r_idx == IDX_W'(i)) r_vec[i*WIDTH_A +: WIDTH_A] <= feat_data;
        end
        if (w_last) begin
          r_idx     <= '0;
          r_label   <= feat_label;
          r_set_cnt <= SET_W'(SETTLE_CYCLES);
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
      if (r_state == ST_SETTLE) begin
        if (r_set_cnt != '0) begin
          r_set_cnt <= r_set_cnt - SET_W'(1);
        end else begin
          r_class <= clf_out;
          r_match <= (clf_out == r_label);
        end
      end
    end
  end

`ifdef MLP_SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] r_wdog;
  logic [CNT_W-1:0] w_wdog_inc;

  // Drop on the (2^CNT_W-1)th consecutive stalled EMIT cycle.
  assign w_wdog_inc = r_wdog + CNT_W'(1);
  assign w_drop     = (r_state == ST_EMIT) && !res_ready && (&w_wdog_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_wdog <= '0;
    else if ((r_state == ST_EMIT) && !res_ready) r_wdog <= w_drop ? '0 : w_wdog_inc;
    else                                       r_wdog <= '0;
  end
`else
  assign w_drop = 1'b0;
`endif

  mlp_seq_stats #(.CNT_W(CNT_W)) u_stats (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_res_hs      (w_res_hs),
    .i_res_match   (r_match),
    .i_stat_clr    (stat_clr),
`ifdef MLP_SEQ_TIMEOUT_EN
    .i_drop        (w_drop),
    .o_drop_cnt    (drop_cnt),
`endif
    .o_total_cnt   (total_cnt),
    .o_correct_cnt (correct_cnt)
  );

  assign clf_inp   = r_vec;
  assign res_class = r_class;
  assign res_match = r_match;

endmodule

// File: tb/tb_mlp_sample_sequencer.sv
// Directed bench: instance A uses default parameters, instance B uses SETTLE_CYCLES=0, CNT_W=2.
module tb_mlp_sample_sequencer;
  localparam int NA = 11;
  localparam int WA = 4;
  localparam int OW = 3;

  typedef struct packed {
    logic [OW-1:0] cls;
    logic          m;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  int   exp_tot[2];
  int   exp_cor[2];
  int   cnt_max[2] = '{65535, 3};

  logic           a_feat_valid, a_feat_ready, a_res_valid, a_res_ready, a_res_match, a_busy, a_stat_clr;
  logic [WA-1:0]  a_feat_data;
  logic [OW-1:0]  a_feat_label, a_clf_out, a_res_class;
  logic [NA*WA-1:0] a_clf_inp;
  logic [15:0]    a_total_cnt, a_correct_cnt;

  logic           b_feat_valid, b_feat_ready, b_res_valid, b_res_ready, b_res_match, b_busy, b_stat_clr;
  logic [WA-1:0]  b_feat_data;
  logic [OW-1:0]  b_feat_label, b_clf_out, b_res_class;
  logic [NA*WA-1:0] b_clf_inp;
  logic [1:0]     b_total_cnt, b_correct_cnt;
`ifdef MLP_SEQ_TIMEOUT_EN
  logic [15:0]    a_drop_cnt;
  logic [1:0]     b_drop_cnt;
`endif

  // Changes every cycle so the capture instant is observable.
  assign b_clf_out = cyc[2:0];

  mlp_sample_sequencer u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .feat_valid(a_feat_valid), .feat_ready(a_feat_ready), .feat_data(a_feat_data), .feat_label(a_feat_label),
    .clf_inp(a_clf_inp), .clf_out(a_clf_out),
    .res_valid(a_res_valid), .res_ready(a_res_ready), .res_class(a_res_class), .res_match(a_res_match),
    .busy(a_busy), .stat_clr(a_stat_clr), .total_cnt(a_total_cnt),
`ifdef MLP_SEQ_TIMEOUT_EN
    .drop_cnt(a_drop_cnt),
`endif
    .correct_cnt(a_correct_cnt)
  );

  mlp_sample_sequencer #(.SETTLE_CYCLES(0), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .feat_valid(b_feat_valid), .feat_ready(b_feat_ready), .feat_data(b_feat_data), .feat_label(b_feat_label),
    .clf_inp(b_clf_inp), .clf_out(b_clf_out),
    .res_valid(b_res_valid), .res_ready(b_res_ready), .res_class(b_res_class), .res_match(b_res_match),
    .busy(b_busy), .stat_clr(b_stat_clr), .total_cnt(b_total_cnt),
`ifdef MLP_SEQ_TIMEOUT_EN
    .drop_cnt(b_drop_cnt),
`endif
    .correct_cnt(b_correct_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cyc is the index of the current cycle, stable at every negedge and at the next posedge.
  initial forever begin
    @(posedge clk);
    #1 cyc++;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic f_fr(input bit sel);   return sel ? b_feat_ready : a_feat_ready; endfunction
  function automatic logic f_rv(input bit sel);   return sel ? b_res_valid : a_res_valid; endfunction
  function automatic logic f_rm(input bit sel);   return sel ? b_res_match : a_res_match; endfunction
  function automatic logic f_busy(input bit sel); return sel ? b_busy : a_busy; endfunction
  function automatic logic [OW-1:0] f_rc(input bit sel); return sel ? b_res_class : a_res_class; endfunction
  function automatic int f_tot(input bit sel); return sel ? int'(b_total_cnt) : int'(a_total_cnt); endfunction
  function automatic int f_cor(input bit sel); return sel ? int'(b_correct_cnt) : int'(a_correct_cnt); endfunction

  task automatic set_feat(input bit sel, input logic v, input logic [WA-1:0] d, input logic [OW-1:0] l);
    if (sel) begin b_feat_valid = v; b_feat_data = d; b_feat_label = l; end
    else     begin a_feat_valid = v; a_feat_data = d; a_feat_label = l; end
  endtask

  task automatic set_res(input bit sel, input logic rr, input logic clr);
    if (sel) begin b_res_ready = rr; b_stat_clr = clr; end
    else     begin a_res_ready = rr; a_stat_clr = clr; end
  endtask

  // Word i = base + i*step; non-last beats carry a wrong label. On B the label is chosen to match.
  task automatic send(input bit sel, input logic [WA-1:0] base, input logic [WA-1:0] step,
                      input logic [OW-1:0] lbl_in, output int t_last);
    logic [OW-1:0] lbl;
    logic [OW-1:0] cls;
    int n;
    lbl = lbl_in;
    t_last = cyc;
    for (int i = 0; i < NA; i++) begin
      n = 0;
      while (!f_fr(sel) && n < 100) begin @(negedge clk); n++; end
      check("feat_ready_load", f_fr(sel), 1);
      t_last = cyc;
      if (sel && i == NA-1) lbl = OW'(cyc + 1);
      set_feat(sel, 1'b1, base + WA'(i) * step, (i == NA-1) ? lbl : ~lbl);
      @(negedge clk);
    end
    set_feat(sel, 1'b0, '0, '0);
    cls = sel ? OW'(t_last + 1) : a_clf_out;
    if (sel) sb_b.push_back({cls, cls == lbl});
    else     sb_a.push_back({cls, cls == lbl});
  endtask

  task automatic get_result(input bit sel, input int exp_cyc, input int hold, input bit clr);
    int n;
    exp_t e;
    set_res(sel, hold == 0, 1'b0);
    n = 0;
    while (!f_rv(sel) && n < 200) begin @(negedge clk); n++; end
    check("res_valid_rise", f_rv(sel), 1);
    check("latency_cycle", cyc, exp_cyc);
    e = '0;
    check("scoreboard_nonempty", (sel ? sb_b.size() : sb_a.size()) > 0, 1);
    if (sel && sb_b.size() > 0) e = sb_b.pop_front();
    else if (!sel && sb_a.size() > 0) e = sb_a.pop_front();
    check("res_class", f_rc(sel), e.cls);
    check("res_match", f_rm(sel), e.m);
    check("busy_emit", f_busy(sel), 1);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", f_rv(sel), 1);
      check("hold_class", f_rc(sel), e.cls);
      check("hold_match", f_rm(sel), e.m);
      check("hold_feat_ready", f_fr(sel), 0);
      check("hold_total", f_tot(sel), exp_tot[sel]);
    end
    set_res(sel, 1'b1, clr);
    @(negedge clk);
    set_res(sel, 1'b1, 1'b0);
    if (clr) begin
      exp_tot[sel] = 0;
      exp_cor[sel] = 0;
    end else begin
      if (exp_tot[sel] < cnt_max[sel]) exp_tot[sel]++;
      if (e.m && exp_cor[sel] < cnt_max[sel]) exp_cor[sel]++;
    end
    check("valid_after_hs", f_rv(sel), 0);
    check("feat_ready_after_hs", f_fr(sel), 1);
    check("total_cnt", f_tot(sel), exp_tot[sel]);
    check("correct_cnt", f_cor(sel), exp_cor[sel]);
  endtask

  initial begin
    int t;
    int n;
    rst_n = 1'b0;
    set_feat(0, 1'b0, '0, '0);
    set_feat(1, 1'b0, '0, '0);
    set_res(0, 1'b1, 1'b0);
    set_res(1, 1'b1, 1'b0);
    a_clf_out = '0;
    exp_tot = '{0, 0};
    exp_cor = '{0, 0};
    repeat (2) @(negedge clk);
    check("rst_clf_inp", a_clf_inp, 0);
    check("rst_res_valid", a_res_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_res_class", a_res_class, 0);
    check("rst_res_match", a_res_match, 0);
    check("rst_total", a_total_cnt, 0);
    check("rst_correct", a_correct_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst_a", a_feat_ready, 1);
    check("ready_after_rst_b", b_feat_ready, 1);

    // Basic matching sample.
    a_clf_out = 3'd3;
    send(0, 4'd1, 4'd1, 3'd3, t);
    check("clf_inp_basic", a_clf_inp, 44'hBA987654321);
    check("busy_settle", a_busy, 1);
    check("feat_ready_settle", a_feat_ready, 0);
    get_result(0, t + 10, 0, 1'b0);

    // Mismatch with 20 cycles of back-pressure.
    a_clf_out = 3'd2;
    send(0, 4'd1, 4'd1, 3'd5, t);
    get_result(0, t + 10, 20, 1'b0);

    // Clear coincident with the handshake.
    a_clf_out = 3'd4;
    send(0, 4'd1, 4'd1, 3'd4, t);
    get_result(0, t + 10, 0, 1'b1);

    // Zero settle time and 2-bit saturating counters.
    for (int s = 0; s < 5; s++) begin
      send(1, WA'(s), 4'd3, 3'd0, t);
      get_result(1, t + 2, 0, 1'b0);
    end

    // Reset in the middle of a load; untouched slots still hold the previous sample.
    for (int i = 0; i < 5; i++) begin
      set_feat(0, 1'b1, 4'hF, 3'd7);
      @(negedge clk);
    end
    set_feat(0, 1'b0, '0, '0);
    check("partial_vec", a_clf_inp, 44'hBA9876FFFFF);
    #2 rst_n = 1'b0;
    #1 check("clf_inp_in_rst", a_clf_inp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_tot = '{0, 0};
    exp_cor = '{0, 0};
    @(negedge clk);
    check("clf_inp_after_rst", a_clf_inp, 0);
    check("ready_after_midrst", a_feat_ready, 1);
    check("total_after_midrst", a_total_cnt, 0);
    check("b_total_after_midrst", b_total_cnt, 0);
    a_clf_out = 3'd6;
    send(0, 4'd11, 4'hF, 3'd6, t);
    check("clf_inp_reload", a_clf_inp, 44'h123456789AB);
    get_result(0, t + 10, 0, 1'b0);

`ifdef MLP_SEQ_TIMEOUT_EN
    // With CNT_W=2 a result stalled for 3 EMIT cycles is dropped.
    send(1, 4'd2, 4'd1, 3'd0, t);
    set_res(1, 1'b0, 1'b0);
    n = 0;
    while (!b_res_valid && n < 50) begin @(negedge clk); n++; end
    for (int k = 0; k < 3; k++) begin
      check("drop_hold_valid", b_res_valid, 1);
      @(negedge clk);
    end
    check("drop_valid_fell", b_res_valid, 0);
    check("drop_cnt", b_drop_cnt, 1);
    check("drop_total_unchanged", b_total_cnt, exp_tot[1]);
    check("drop_ready_load", b_feat_ready, 1);
    if (sb_b.size() > 0) void'(sb_b.pop_front());
    set_res(1, 1'b1, 1'b0);
`else
    n = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mlp_sample_sequencer.md
Name: mlp_sample_sequencer

Overview:
Synthesizable streaming front-end for the combinational printed-MLP classifier (`top`, ports inp/out).
- Accepts feature words serially over a valid/ready stream and assembles one NUM_A-feature vector.
- Holds the vector on the classifier input for a programmable settle time, then captures the class.
- Emits the class and a match flag against the golden label over a valid/ready result stream.
- Replaces file-driven, fixed-delay stimulus with on-chip, parametrised, back-pressured evaluation.

Parameters:
NUM_A, 11, features per sample
WIDTH_A, 4, bits per feature
OUTWIDTH, 3, class index width
SETTLE_CYCLES, 8, clk cycles classifier input is held stable before capture (>=0)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
feat_valid  in  1  feature word valid
feat_ready  out  1  sequencer accepts feature word
feat_data  in  WIDTH_A  feature word, feature 0 first
feat_label  in  OUTWIDTH  golden class, sampled on the last feature beat only
clf_inp  out  NUM_A*WIDTH_A  to classifier inp; feature i at [(i+1)*WIDTH_A-1 : i*WIDTH_A]
clf_out  in  OUTWIDTH  from classifier out
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_class  out  OUTWIDTH  captured class
res_match  out  1  res_class == latched label
busy  out  1  high in SETTLE or EMIT
stat_clr  in  1  synchronous clear of statistics
total_cnt  out  CNT_W  results handed off
correct_cnt  out  CNT_W  results handed off with res_match=1

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=LOAD, feature index=0
  - clf_inp=0, res_class=0, res_match=0, res_valid=0, busy=0
  - counters=0
  - feat_ready=1 on the first cycle after reset release.
- FSM states: LOAD, SETTLE, EMIT.
- LOAD:
  - feat_ready=1.
  - Each feat_valid&feat_ready beat writes feat_data into slot idx, then increments idx.
  - On the beat with idx==NUM_A-1: latch feat_label, set idx=0, load settle counter with SETTLE_CYCLES, go to SETTLE.
- SETTLE:
  - feat_ready=0; clf_inp held constant.
  - If counter!=0, decrement.
  - If counter==0, capture clf_out into res_class, compute res_match, go to EMIT.
- EMIT:
  - res_valid=1; res_class and res_match stable until the handshake.
  - On res_valid&res_ready: update counters, go to LOAD next cycle.
- Latency: last feature accepted in cycle T gives res_valid=1 from cycle T+2+SETTLE_CYCLES. With SETTLE_CYCLES=0, res_valid rises at T+2.
- Throughput: one sample per NUM_A+2+SETTLE_CYCLES cycles when res_ready is held high.
- No feature beat is ever accepted in SETTLE or EMIT. Upstream holds the word until ready.
- clf_inp keeps the previous sample's slots until they are overwritten; slots are not cleared between samples.
- Counters:
  - Saturate at 2^CNT_W-1; they do not wrap.
  - total_cnt increments on every result handshake.
  - correct_cnt increments on a handshake with res_match=1.
- stat_clr asserted in the same cycle as a handshake: clear wins, both counters become 0, and that sample is not counted.
- stat_clr has no effect on the FSM or the datapath.
- rst_n asserted mid-sample discards partial features and any pending result.

Optional Feature:
MLP_SEQ_TIMEOUT_EN
- Defined:
  - A watchdog counter (width CNT_W) counts consecutive EMIT cycles with res_ready=0.
  - At 2^CNT_W-1 the result is dropped: res_valid falls, state returns to LOAD, counters are unchanged, and an extra output port drop_cnt [CNT_W] increments (saturating, cleared by stat_clr).
- Undefined: no watchdog and no drop_cnt port; EMIT waits indefinitely.

Decomposition:
- Package mlp_seq_pkg:
  - State enum (LOAD, SETTLE, EMIT).
  - Function for the saturating increment.
  - Localparam IDX_W=$clog2(NUM_A), SET_W=$clog2(SETTLE_CYCLES+1) (minimum 1).
- Sub-module mlp_seq_stats: counters, saturation, stat_clr priority, optional drop_cnt.
- FSM and vector assembly stay in mlp_sample_sequencer.

Test Plan:
- Basic sample, default parameters. Send 11 words 1..11, label=3, stub clf_out=3, res_ready=1.
  -> clf_inp=0xBA987654321, res_valid at T+10, res_class=3, res_match=1, total=1, correct=1.
- Mismatch plus back-pressure. Same words, label=5, clf_out=2, res_ready low for 20 cycles.
  -> res_valid held, res_class=2, res_match=0; counters update once only, after ready rises (total=2, correct=1); feat_ready=0 throughout.
- SETTLE_CYCLES=0 with stub clf_out changing on every clk.
  -> res_valid at T+2; captured value equals clf_out in cycle T+1.
- Saturation with CNT_W=2. Run 5 matching samples.
  -> total_cnt=3 and correct_cnt=3, held.
- Clear coincident with handshake. stat_clr in the handshake cycle.
  -> both counters=0.
- Reset mid-load. Reset after 5 beats, then a full sample.
  -> clf_inp=0 after reset; the new sample's first word lands in slot 0; result correct.
  - With MLP_SEQ_TIMEOUT_EN and CNT_W=4: res_ready=0 for 15 EMIT cycles -> result dropped, drop_cnt=1.
